// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: opcodes, write-back select encodings and
// the control half of the MEM/WB latch.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic [1:0]            sel;
    } wb_ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 32-entry integer register file: two combinational read ports with
// write-through bypass, one write port, x0 hard-wired to zero.
module reg_file
    import rv32i_pkg::*;
#(
    parameter int XLEN       = rv32i_pkg::XLEN,
    parameter int REG_ADDR_W = rv32i_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);
    localparam int NREGS = 1 << REG_ADDR_W;

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass so decode sees a value in the same cycle it is being written.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (we && raddr1 == waddr) rdata1 = wdata;
        if (we && raddr2 == waddr) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/wb_stage.sv
// rv32i write-back stage: MEM/WB latch, result select, register commit,
// retired-instruction counter and sticky reserved-select flag.
module wb_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN       = rv32i_pkg::XLEN,
    parameter int REG_ADDR_W = rv32i_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_write_to_reg,
    input  logic [1:0]            mem_data_to_reg_sel,
    input  logic [XLEN-1:0]       mem_alu_out,
    input  logic [XLEN-1:0]       mem_load_data,
    input  logic [XLEN-1:0]       mem_pc_plus4,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [63:0]           instret,
    output logic                  illegal_sel
);
    wb_ctrl_t        ctrl;
    logic [XLEN-1:0] alu_q, load_q, pc4_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl   <= '0;
            alu_q  <= '0;
            load_q <= '0;
            pc4_q  <= '0;
        end else if (flush) begin
            ctrl.valid <= 1'b0;
        end else if (!hold) begin
            ctrl.valid <= mem_valid;
            ctrl.rd    <= mem_rd;
            ctrl.we    <= mem_write_to_reg;
            ctrl.sel   <= mem_data_to_reg_sel;
            alu_q      <= mem_alu_out;
            load_q     <= mem_load_data;
            pc4_q      <= mem_pc_plus4;
        end
    end

    always_comb begin
        case (ctrl.sel)
            WB_SEL_ALU: wb_data = alu_q;
            WB_SEL_MEM: wb_data = load_q;
            WB_SEL_PC4: wb_data = pc4_q;
            default:    wb_data = '0;
        endcase
    end

    assign wb_rd = ctrl.rd;
    assign wb_we = ctrl.valid & ctrl.we & (ctrl.rd != '0) &
                   (ctrl.sel != WB_SEL_RSVD) & !hold;

    // Retirement counts every valid instruction leaving WB, writer or not;
    // a flushed cycle does not count even though its commit still happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret     <= '0;
            illegal_sel <= 1'b0;
        end else begin
            if (ctrl.valid && !hold && !flush) instret <= instret + 64'd1;
            if (ctrl.valid && ctrl.we && ctrl.sel == WB_SEL_RSVD && !hold)
                illegal_sel <= 1'b1;
        end
    end

    reg_file #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

endmodule
